// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mul/div operations to the shared multi-cycle
// multdiv unit, stalls the pipeline while it runs, bounds the wait with a
// timeout and returns the result (or an rstatus exception code) through a
// ready/valid writeback port.
module multdiv_sequencer #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        isMul_x,
    input  logic        isDiv_x,
    input  logic [31:0] operandA_x,
    input  logic [31:0] operandB_x,
    input  logic [4:0]  rd_x,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        md_timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    // Exception writeback goes to rstatus with a per-op cause code.
    localparam logic [4:0]  EXC_RD   = 5'd30;
    localparam logic [31:0] EXC_MUL  = 32'd4;
    localparam logic [31:0] EXC_DIV  = 32'd5;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             op_div_q,  op_div_d;
    logic [31:0]      opa_q,     opa_d;
    logic [31:0]      opb_q,     opb_d;
    logic [4:0]       rd_q,      rd_d;
    logic [4:0]       wb_rd_q,   wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             timeout_q, timeout_d;
    logic             stall_raw;

    // State register and shadow registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, shadow updates and the combinational stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        timeout_d = timeout_q;
        stall_raw = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_raw = isMul_x | isDiv_x;
                if (isMul_x | isDiv_x) begin
                    op_div_d = ~isMul_x;  // mul wins when both decode
                    opa_d    = operandA_x;
                    opb_d    = operandB_x;
                    rd_d     = rd_x;
                    state_d  = S_START;
                end
            end
            S_START: begin
                stall_raw = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (data_resultRDY) begin
                    if (data_exception) begin
                        wb_rd_d   = EXC_RD;
                        wb_data_d = op_div_q ? EXC_DIV : EXC_MUL;
                        state_d   = S_WB;
                    end else if (rd_q != 5'd0) begin
                        wb_rd_d   = rd_q;
                        wb_data_d = data_result;
                        state_d   = S_WB;
                    end else begin
                        // Result for r0 is discarded; release the pipe now.
                        stall_raw = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    wb_rd_d   = EXC_RD;
                    wb_data_d = op_div_q ? EXC_DIV : EXC_MUL;
                    timeout_d = 1'b1;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                stall_raw = ~wb_ready;
                if (wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; stall is forced low while reset is held.
    assign stall         = stall_raw & reset;
    assign ctrl_MULT     = (state_q == S_START) & ~op_div_q;
    assign ctrl_DIV      = (state_q == S_START) &  op_div_q;
    assign busy          = (state_q != S_IDLE);
    assign wb_valid      = (state_q == S_WB);
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign data_operandA = opa_q;
    assign data_operandB = opb_q;
    assign md_timeout    = timeout_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Testbench for multdiv_sequencer: two instances (MAX_CYCLES 40 and 4) share
// the stimulus; a transaction-level model predicts every output each cycle.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        is_mul = 1'b0, is_div = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_x = '0;
    logic [31:0] res = '0;
    logic        exc = 1'b0, rdy = 1'b0, wb_ready = 1'b1;

    logic        ctrl_mult_o [2];
    logic        ctrl_div_o  [2];
    logic [31:0] opa_o       [2];
    logic [31:0] opb_o       [2];
    logic        stall_o     [2];
    logic        busy_o      [2];
    logic        wb_valid_o  [2];
    logic [4:0]  wbrd_o      [2];
    logic [31:0] wbd_o       [2];
    logic        md_to_o     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    multdiv_sequencer #(.MAX_CYCLES(40)) dut (
        .clock(clock), .reset(reset), .isMul_x(is_mul), .isDiv_x(is_div),
        .operandA_x(op_a), .operandB_x(op_b), .rd_x(rd_x),
        .ctrl_MULT(ctrl_mult_o[0]), .ctrl_DIV(ctrl_div_o[0]),
        .data_operandA(opa_o[0]), .data_operandB(opb_o[0]),
        .data_result(res), .data_exception(exc), .data_resultRDY(rdy),
        .stall(stall_o[0]), .busy(busy_o[0]), .wb_valid(wb_valid_o[0]),
        .wb_rd(wbrd_o[0]), .wb_data(wbd_o[0]), .wb_ready(wb_ready),
        .md_timeout(md_to_o[0])
    );

    multdiv_sequencer #(.MAX_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset), .isMul_x(is_mul), .isDiv_x(is_div),
        .operandA_x(op_a), .operandB_x(op_b), .rd_x(rd_x),
        .ctrl_MULT(ctrl_mult_o[1]), .ctrl_DIV(ctrl_div_o[1]),
        .data_operandA(opa_o[1]), .data_operandB(opb_o[1]),
        .data_result(res), .data_exception(exc), .data_resultRDY(rdy),
        .stall(stall_o[1]), .busy(busy_o[1]), .wb_valid(wb_valid_o[1]),
        .wb_rd(wbrd_o[1]), .wb_data(wbd_o[1]), .wb_ready(wb_ready),
        .md_timeout(md_to_o[1])
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int max_of(int i);
        return (i == 0) ? 40 : 4;
    endfunction

    // Model: m_age counts cycles since the request was accepted (0 = no
    // operation in flight, 1 = start-pulse cycle, >=2 = waiting); m_wb marks
    // a pending writeback.
    int          m_age [2];
    bit          m_wb  [2];
    bit          m_div [2];
    bit          m_to  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];
    logic [4:0]  m_rd  [2];
    logic [4:0]  m_wbrd[2];
    logic [31:0] m_wbd [2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_age[i] = 0; m_wb[i] = 0; m_div[i] = 0; m_to[i] = 0;
                m_a[i] = '0; m_b[i] = '0; m_rd[i] = '0;
                m_wbrd[i] = '0; m_wbd[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_wb[i]) begin
                    if (wb_ready) m_wb[i] = 0;
                end else if (m_age[i] == 0) begin
                    if (is_mul || is_div) begin
                        m_div[i] = !is_mul;
                        m_a[i] = op_a; m_b[i] = op_b; m_rd[i] = rd_x;
                        m_age[i] = 1;
                    end
                end else if (m_age[i] == 1) begin
                    m_age[i] = 2;
                end else if (rdy) begin
                    m_age[i] = 0;
                    if (exc) begin
                        m_wbrd[i] = 5'd30; m_wbd[i] = m_div[i] ? 32'd5 : 32'd4;
                        m_wb[i] = 1;
                    end else if (m_rd[i] != 5'd0) begin
                        m_wbrd[i] = m_rd[i]; m_wbd[i] = res;
                        m_wb[i] = 1;
                    end
                end else if (m_age[i] == max_of(i) + 1) begin
                    m_age[i] = 0;
                    m_wbrd[i] = 5'd30; m_wbd[i] = m_div[i] ? 32'd5 : 32'd4;
                    m_wb[i] = 1; m_to[i] = 1;
                end else begin
                    m_age[i]++;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    logic es;
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset)                 es = 1'b0;
            else if (m_wb[i])           es = !wb_ready;
            else if (m_age[i] == 0)     es = is_mul | is_div;
            else if (m_age[i] >= 2 && rdy && !exc && m_rd[i] == 5'd0) es = 1'b0;
            else                        es = 1'b1;
            chk($sformatf("d%0d.stall", i), 32'(stall_o[i]), 32'(es));
            chk($sformatf("d%0d.ctrl_MULT", i), 32'(ctrl_mult_o[i]),
                32'(!m_wb[i] && m_age[i] == 1 && !m_div[i]));
            chk($sformatf("d%0d.ctrl_DIV", i), 32'(ctrl_div_o[i]),
                32'(!m_wb[i] && m_age[i] == 1 && m_div[i]));
            chk($sformatf("d%0d.busy", i), 32'(busy_o[i]), 32'(m_wb[i] || m_age[i] != 0));
            chk($sformatf("d%0d.wb_valid", i), 32'(wb_valid_o[i]), 32'(m_wb[i]));
            chk($sformatf("d%0d.md_timeout", i), 32'(md_to_o[i]), 32'(m_to[i]));
            chk($sformatf("d%0d.opA", i), opa_o[i], m_a[i]);
            chk($sformatf("d%0d.opB", i), opb_o[i], m_b[i]);
            if (m_wb[i]) begin
                chk($sformatf("d%0d.wb_rd", i), 32'(wbrd_o[i]), 32'(m_wbrd[i]));
                chk($sformatf("d%0d.wb_data", i), wbd_o[i], m_wbd[i]);
            end
        end
    end

    task automatic pc();
        @(posedge clock); #1;
    endtask

    task automatic nc();
        @(negedge clock);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            if (!busy_o[0] && !busy_o[1]) return;
            pc();
        end
        n_tests++; n_fail++;
        $display("FAIL idle_wait: busy did not drop within 100 cycles");
    endtask

    task automatic req(input logic m, input logic d, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] b);
        pc(); is_mul = m; is_div = d; rd_x = r; op_a = a; op_b = b;   // cycle 0
    endtask

    initial begin
        // Reset with a request present: every output must read 0.
        is_mul = 1'b1;
        nc();
        chk("rst.stall", 32'(stall_o[0]), 32'd0);
        chk("rst.busy", 32'(busy_o[0]), 32'd0);
        chk("rst.md_timeout", 32'(md_to_o[1]), 32'd0);
        chk("rst.wb_data", wbd_o[0], 32'd0);
        is_mul = 1'b0;
        pc(); reset = 1'b1;

        // Basic mul: 6*7 -> r5.
        req(1, 0, 5'd5, 32'd6, 32'd7);
        nc(); chk("mul.stall_c0", 32'(stall_o[0]), 32'd1);
        pc(); is_mul = 0;                                              // c1
        nc(); chk("mul.ctrl_MULT_c1", 32'(ctrl_mult_o[0]), 32'd1);
              chk("mul.ctrl_DIV_c1", 32'(ctrl_div_o[0]), 32'd0);
              chk("mul.opA_c1", opa_o[0], 32'd6);
        pc(); rdy = 1; res = 32'd42;                                   // c2
        nc(); chk("mul.ctrl_MULT_c2", 32'(ctrl_mult_o[0]), 32'd0);
              chk("mul.stall_c2", 32'(stall_o[0]), 32'd1);
        pc(); rdy = 0;                                                 // c3
        nc(); chk("mul.wb_valid_c3", 32'(wb_valid_o[0]), 32'd1);
              chk("mul.wb_rd_c3", 32'(wbrd_o[0]), 32'd5);
              chk("mul.wb_data_c3", wbd_o[0], 32'd42);
              chk("mul.stall_c3", 32'(stall_o[0]), 32'd0);
        pc();                                                          // c4
        nc(); chk("mul.wb_valid_c4", 32'(wb_valid_o[0]), 32'd0);
        wait_idle();

        // rd = 0: no writeback, stall drops in the RDY cycle.
        req(1, 0, 5'd0, 32'd1, 32'd2);
        pc(); is_mul = 0;                                              // c1
        pc(); rdy = 1; res = 32'd99;                                   // c2
        nc(); chk("rd0.stall_c2", 32'(stall_o[0]), 32'd0);
        pc(); rdy = 0;                                                 // c3
        nc(); chk("rd0.wb_valid_c3", 32'(wb_valid_o[0]), 32'd0);
              chk("rd0.busy_c3", 32'(busy_o[0]), 32'd0);
        wait_idle();

        // Writeback backpressure: grant withheld for three WB cycles.
        req(1, 0, 5'd9, 32'd3, 32'd5);
        wb_ready = 0;
        pc(); is_mul = 0;                                              // c1
        pc();                                                          // c2
        pc(); rdy = 1; res = 32'd15;                                   // c3
        pc(); rdy = 0;                                                 // c4
        for (int k = 0; k < 3; k++) begin                              // c4..c6
            nc(); chk("bp.wb_valid", 32'(wb_valid_o[0]), 32'd1);
                  chk("bp.stall", 32'(stall_o[0]), 32'd1);
                  chk("bp.wb_rd", 32'(wbrd_o[0]), 32'd9);
                  chk("bp.wb_data", wbd_o[0], 32'd15);
            pc();
        end
        wb_ready = 1;                                                  // c7
        nc(); chk("bp.stall_grant", 32'(stall_o[0]), 32'd0);
              chk("bp.wb_valid_grant", 32'(wb_valid_o[0]), 32'd1);
        pc();                                                          // c8
        nc(); chk("bp.wb_valid_after", 32'(wb_valid_o[0]), 32'd0);
        wait_idle();

        // Simultaneous decode: mul wins.
        req(1, 1, 5'd4, 32'd2, 32'd3);
        pc(); is_mul = 0; is_div = 0;                                  // c1
        nc(); chk("both.ctrl_MULT", 32'(ctrl_mult_o[0]), 32'd1);
              chk("both.ctrl_DIV", 32'(ctrl_div_o[0]), 32'd0);
        pc(); pc();                                                    // c2, c3
        pc(); rdy = 1; res = 32'd6;                                    // c4
        pc(); rdy = 0;                                                 // c5
        nc(); chk("both.wb_data", wbd_o[0], 32'd6);
        wait_idle();

        // Div with RDY on the last allowed WAIT cycle of the MAX_CYCLES=4 unit.
        req(0, 1, 5'd12, 32'd50, 32'd7);
        pc(); is_div = 0;                                              // c1
        nc(); chk("div.ctrl_DIV", 32'(ctrl_div_o[1]), 32'd1);
        pc(); pc(); pc();                                              // c2..c4
        pc(); rdy = 1; res = 32'd7;                                    // c5
        pc(); rdy = 0;                                                 // c6
        nc(); chk("div.d4_wb_data", wbd_o[1], 32'd7);
              chk("div.d4_wb_rd", 32'(wbrd_o[1]), 32'd12);
              chk("div.d4_md_timeout", 32'(md_to_o[1]), 32'd0);
        wait_idle();

        // Divide by zero with exception at cycle 10.
        req(0, 1, 5'd8, 32'd100, 32'd0);
        pc(); is_div = 0;                                              // c1
        for (int k = 0; k < 5; k++) pc();                              // c2..c6
        nc(); chk("dexc.d4_timeout_wb_data", wbd_o[1], 32'd5);
              chk("dexc.d40_wb_valid_c6", 32'(wb_valid_o[0]), 32'd0);
        pc(); pc(); pc();                                              // c7..c9
        pc(); rdy = 1; exc = 1; res = 32'd0;                           // c10
        pc(); rdy = 0; exc = 0;                                        // c11
        nc(); chk("dexc.wb_rd", 32'(wbrd_o[0]), 32'd30);
              chk("dexc.wb_data", wbd_o[0], 32'd5);
              chk("dexc.md_timeout", 32'(md_to_o[0]), 32'd0);
        wait_idle();

        // Timeout on the MAX_CYCLES=4 unit, then reset during the other's WAIT.
        req(1, 0, 5'd3, 32'd11, 32'd13);
        pc(); is_mul = 0;                                              // c1
        for (int k = 0; k < 5; k++) pc();                              // c2..c6
        nc(); chk("to.wb_valid_c6", 32'(wb_valid_o[1]), 32'd1);
              chk("to.wb_rd_c6", 32'(wbrd_o[1]), 32'd30);
              chk("to.wb_data_c6", wbd_o[1], 32'd4);
        for (int k = 0; k < 3; k++) begin                              // c7..c9
            pc();
            nc(); chk("to.md_timeout_sticky", 32'(md_to_o[1]), 32'd1);
        end
        pc(); reset = 0;                                               // c10
        nc(); chk("rstw.busy", 32'(busy_o[0]), 32'd0);
              chk("rstw.stall", 32'(stall_o[0]), 32'd0);
              chk("rstw.opA", opa_o[0], 32'd0);
              chk("rstw.md_timeout", 32'(md_to_o[1]), 32'd0);
        pc(); reset = 1;                                               // c11
        pc(); rdy = 1; res = 32'd77;                                   // c12
        pc(); rdy = 0;                                                 // c13
        for (int k = 0; k < 3; k++) begin
            nc(); chk("rstw.no_wb", 32'(wb_valid_o[0]), 32'd0);
            pc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the shared multi-cycle multiply/divide unit for the 5-stage pipeline. When the execute-stage instruction decodes as `mul` or `div`, the block stalls the pipeline, latches the operands, and issues a one-cycle start pulse to the multdiv unit. It then waits for the result, bounded by a timeout, and delivers the result or an `rstatus` exception write through a ready/valid writeback handshake.

## Interface
- `MAX_CYCLES`, default 40: number of WAIT cycles without `data_resultRDY` before the operation is declared timed out.
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `isMul_x` in 1: decoded `mul` in the X stage.
- `isDiv_x` in 1: decoded `div` in the X stage.
- `operandA_x` in 32: X-stage source A value.
- `operandB_x` in 32: X-stage source B value.
- `rd_x` in 5: X-stage destination register.
- `ctrl_MULT` out 1: one-cycle start pulse for a multiply.
- `ctrl_DIV` out 1: one-cycle start pulse for a divide.
- `data_operandA` out 32: latched operand A, held stable from START until return to IDLE.
- `data_operandB` out 32: latched operand B, held stable from START until return to IDLE.
- `data_result` in 32: result from the multdiv unit.
- `data_exception` in 1: exception flag from the multdiv unit, sampled with `data_resultRDY`.
- `data_resultRDY` in 1: result-valid strobe from the multdiv unit.
- `stall` out 1: freezes the PC and the F/D and D/X latches.
- `busy` out 1: high whenever state ≠ IDLE.
- `wb_valid` out 1: writeback request.
- `wb_rd` out 5: writeback destination register.
- `wb_data` out 32: writeback data.
- `wb_ready` in 1: writeback port granted this cycle.
- `md_timeout` out 1: sticky flag, set on any timeout, cleared only by reset.

## Operation
States: IDLE, START, WAIT, WB. Each latched value has a shadow register.
- **Reset.**
  - State goes to IDLE, the counter to 0, and all shadow registers to 0.
  - Every output reads 0, including `stall`, `busy`, `wb_valid` and `md_timeout`.
  - Reset asserted mid-operation aborts the operation: no start pulse and no writeback are produced.
- **IDLE.**
  - `stall` = `isMul_x | isDiv_x`, combinationally.
  - On the edge with a request: latch operands, `rd_x` and the op, then go to START.
  - If `isMul_x` and `isDiv_x` are both high, mul wins.
- **START.**
  - Exactly one of `ctrl_MULT`/`ctrl_DIV` is high for this single cycle.
  - `data_resultRDY` is ignored in this state.
  - Counter is cleared; next state is WAIT.
- **WAIT.**
  - The counter increments each cycle.
  - On `data_resultRDY`, capture `data_result`/`data_exception`:
    - On exception, go to WB with `wb_rd`=30 and `wb_data`=4 (mul) or 5 (div).
    - On no exception with latched rd ≠ 0, go to WB with `wb_rd`=latched rd and `wb_data`=result.
    - On no exception with latched rd = 0, skip writeback: `stall` drops combinationally this cycle and the next state is IDLE.
  - If the counter reaches `MAX_CYCLES`-1 with no `data_resultRDY`, go to WB with the exception encoding and set `md_timeout`.
- **WB.**
  - `wb_valid`=1 and `stall`=!`wb_ready`.
  - On `wb_ready`, go to IDLE.
  - `wb_rd`/`wb_data` are held stable until accepted.
- **Other states.** `stall`=1 in START and WAIT, except the rd=0 completion cycle.
- **Counter width.** clog2(`MAX_CYCLES`+1); no wrap is possible.

## Timing
- Request seen in IDLE at cycle 0; START at cycle 1; first WAIT cycle is cycle 2.
- `data_resultRDY` at cycle k ≥ 2 puts WB at cycle k+1.
  - With `wb_ready`=1, `stall` is low in cycle k+1 and the pipeline advances at the end of k+1.
  - Minimum stall length is 3 cycles (cycles 0–2, with `data_resultRDY` at cycle 2).
- Because the request cycle is never IDLE again for the same instruction, no double issue can occur.
- Timeout: the last WAIT cycle is cycle `MAX_CYCLES`+1, and WB follows at cycle `MAX_CYCLES`+2.
- `data_operandA`/`data_operandB` are valid at the START edge and stay constant through WAIT.

## Test plan
- **Basic mul.** `mul` with `rd_x`=5, A=6, B=7; `data_resultRDY` at cycle 2 with result 42; `wb_ready`=1 → `ctrl_MULT` high in cycle 1 only; `wb_valid`/`wb_rd`=5/`wb_data`=42 in cycle 3; `stall` high in cycles 0–2, low in cycle 3.
- **Div exception.** `div` by 0 with `rd_x`=8; `data_resultRDY`+`data_exception` at cycle 10 → `wb_rd`=30, `wb_data`=5; `md_timeout`=0.
- **Timeout.** `MAX_CYCLES`=4, `mul`, `data_resultRDY` never asserted → WB in cycle 6 with `wb_rd`=30, `wb_data`=4; `md_timeout` stays 1 afterwards.
- **Writeback backpressure and rd=0.** `wb_ready` low for 3 cycles in WB → `wb_valid`, `wb_rd`, `wb_data` and `stall` all held; release on the grant edge. Separately, `mul` with `rd_x`=0 and a valid result → no `wb_valid`; `stall` low in the RDY cycle.
- **Reset and simultaneous decode.** Reset pulsed during WAIT → all outputs 0 immediately; no writeback follows. `isMul_x` and `isDiv_x` both high → only `ctrl_MULT` pulses.
